// File: rtl/imm_ext_if.sv
// Request/acknowledge and result handshake bundle for imm_ext_arbiter.
// The master side is the two requesters plus the result consumer.
interface imm_ext_if;
    logic        req0;
    logic        req1;
    logic [5:0]  imm0;
    logic [5:0]  imm1;
    logic        zx0;
    logic        zx1;
    logic        pfx0;
    logic        pfx1;
    logic        ack0;
    logic        ack1;
    logic        out_valid;
    logic [17:0] out_imm;
    logic        out_src;
    logic        out_ready;

    modport master (
        output req0, req1, imm0, imm1, zx0, zx1, pfx0, pfx1, out_ready,
        input  ack0, ack1, out_valid, out_imm, out_src
    );

    modport slave (
        input  req0, req1, imm0, imm1, zx0, zx1, pfx0, pfx1, out_ready,
        output ack0, ack1, out_valid, out_imm, out_src
    );
endinterface

// File: rtl/imm_ext_arbiter.sv
// Round-robin shared 6-to-18-bit immediate extender with registered valid/ready output.
// Define IMM_PREFIX_EN to build prefix merging (LOCK state + prefix register).
module imm_ext_arbiter (
    input  logic      clk,
    input  logic      rst,
    imm_ext_if.slave  bus
);

`ifdef IMM_PREFIX_EN
    typedef enum logic [1:0] {IDLE = 2'd0, VALID = 2'd1, LOCK = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, VALID = 2'd1} state_t;
`endif

    state_t      state_q, state_d;
    logic        ack0_q, ack0_d, ack1_q, ack1_d;
    logic        valid_q, valid_d;
    logic        src_q, src_d;
    logic [17:0] imm_q, imm_d;
    logic        last_grant_q, last_grant_d;

    logic        grant_any, grant_id;
    logic [5:0]  sel_imm;
    logic        sel_zx;

`ifdef IMM_PREFIX_EN
    logic [5:0]  prefix_q, prefix_d;
    logic        owner_q, owner_d;
    logic        sel_pfx;
    logic        own_req, own_zx, own_pfx;
    logic [5:0]  own_imm;
`else
    logic        unused_pfx;
    assign unused_pfx = bus.pfx0 ^ bus.pfx1;
`endif

    function automatic logic [17:0] ext6(input logic [5:0] chunk, input logic zx);
        return zx ? {12'b0, chunk} : {{12{chunk[5]}}, chunk};
    endfunction

    function automatic logic [17:0] ext12(input logic [11:0] chunk, input logic zx);
        return zx ? {6'b0, chunk} : {{6{chunk[11]}}, chunk};
    endfunction

    // On a tie the port that did not win last time gets the grant.
    assign grant_any = bus.req0 | bus.req1;
    assign grant_id  = (bus.req0 & bus.req1) ? ~last_grant_q : bus.req1;
    assign sel_imm   = grant_id ? bus.imm1 : bus.imm0;
    assign sel_zx    = grant_id ? bus.zx1  : bus.zx0;

`ifdef IMM_PREFIX_EN
    assign sel_pfx = grant_id ? bus.pfx1 : bus.pfx0;
    assign own_req = owner_q  ? bus.req1 : bus.req0;
    assign own_imm = owner_q  ? bus.imm1 : bus.imm0;
    assign own_zx  = owner_q  ? bus.zx1  : bus.zx0;
    assign own_pfx = owner_q  ? bus.pfx1 : bus.pfx0;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d      = state_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        valid_d      = valid_q;
        src_d        = src_q;
        imm_d        = imm_q;
        last_grant_d = last_grant_q;
`ifdef IMM_PREFIX_EN
        prefix_d     = prefix_q;
        owner_d      = owner_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    last_grant_d = grant_id;
                    ack0_d       = ~grant_id;
                    ack1_d       = grant_id;
`ifdef IMM_PREFIX_EN
                    if (sel_pfx) begin
                        prefix_d = sel_imm;
                        owner_d  = grant_id;
                        state_d  = LOCK;
                    end else
`endif
                    begin
                        imm_d   = ext6(sel_imm, sel_zx);
                        src_d   = grant_id;
                        valid_d = 1'b1;
                        state_d = VALID;
                    end
                end
            end
            VALID: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
`ifdef IMM_PREFIX_EN
            LOCK: begin
                // The ack cycle still shows the chunk just taken, so skip it.
                if (own_req && !(ack0_q || ack1_q)) begin
                    ack0_d = ~owner_q;
                    ack1_d = owner_q;
                    if (own_pfx) begin
                        prefix_d = own_imm;
                    end else begin
                        imm_d    = ext12({prefix_q, own_imm}, own_zx);
                        src_d    = owner_q;
                        valid_d  = 1'b1;
                        prefix_d = 6'd0;
                        state_d  = VALID;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            valid_q      <= 1'b0;
            src_q        <= 1'b0;
            imm_q        <= 18'd0;
            last_grant_q <= 1'b1;
`ifdef IMM_PREFIX_EN
            // NOTE: the prefix register is reset so a reset in LOCK cannot leak a stale chunk.
            prefix_q     <= 6'd0;
            owner_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            valid_q      <= valid_d;
            src_q        <= src_d;
            imm_q        <= imm_d;
            last_grant_q <= last_grant_d;
`ifdef IMM_PREFIX_EN
            prefix_q     <= prefix_d;
            owner_q      <= owner_d;
`endif
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.out_valid = valid_q;
    assign bus.out_imm   = imm_q;
    assign bus.out_src   = src_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed self-checking bench for imm_ext_arbiter; prefix scenarios run only when
// IMM_PREFIX_EN is defined, otherwise the pfx-ignored scenario runs.
`timescale 1ns/1ps
module tb_imm_ext_arbiter;
    logic clk = 1'b0;
    logic rst;
    imm_ext_if bus();

    imm_ext_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.imm0 = 6'd0; bus.imm1 = 6'd0;
        bus.zx0  = 1'b0; bus.zx1  = 1'b0;
        bus.pfx0 = 1'b0; bus.pfx1 = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic drive_req(input logic port, input logic [5:0] imm,
                             input logic zx, input logic pfx);
        if (port) begin
            bus.req1 = 1'b1; bus.imm1 = imm; bus.zx1 = zx; bus.pfx1 = pfx;
        end else begin
            bus.req0 = 1'b1; bus.imm0 = imm; bus.zx0 = zx; bus.pfx0 = pfx;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #2;
        tests_run++;
        if ({bus.ack0, bus.ack1, bus.out_valid, bus.out_src} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want 0000", {bus.ack0, bus.ack1, bus.out_valid, bus.out_src});
        end
        tests_run++;
        if (bus.out_imm !== 18'h00000) begin
            tests_failed++;
            $display("FAIL reset_imm: got %h want 00000", bus.out_imm);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus.ack0, bus.ack1, bus.out_valid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_idle: got %b want 000", {bus.ack0, bus.ack1, bus.out_valid});
        end
    endtask

    task automatic test_hold_stable();
        @(posedge clk); #1;
        drive_req(1'b0, 6'b100000, 1'b0, 1'b0);
        @(negedge clk);
        tests_run++;
        if (bus.ack0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_early_ack: got %b want 0", bus.ack0);
        end
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({bus.ack0, bus.ack1, bus.out_valid, bus.out_src} !== 4'b1010) begin
            tests_failed++;
            $display("FAIL hold_ack: got %b want 1010", {bus.ack0, bus.ack1, bus.out_valid, bus.out_src});
        end
        tests_run++;
        if (bus.out_imm !== 18'h3FFE0) begin
            tests_failed++;
            $display("FAIL hold_imm: got %h want 3ffe0", bus.out_imm);
        end
        @(posedge clk); #1 bus.req0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.ack0, bus.out_valid, bus.out_imm} !== {1'b0, 1'b1, 18'h3FFE0}) begin
                tests_failed++;
                $display("FAIL hold_stable%0d: got ack0=%b valid=%b imm=%h want 0 1 3ffe0",
                         i, bus.ack0, bus.out_valid, bus.out_imm);
            end
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(posedge clk); #1 bus.out_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_accept: got valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_extension();
        logic        port_v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [5:0]  imm_v  [4] = '{6'h20, 6'h1F, 6'h3F, 6'h2A};
        logic        zx_v   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [17:0] exp_v  [4] = '{18'h00020, 18'h0001F, 18'h0003F, 18'h3FFEA};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
            drive_req(port_v[i], imm_v[i], zx_v[i], 1'b0);
            @(posedge clk);
            @(negedge clk);
            tests_run++;
            if ({bus.ack0, bus.ack1, bus.out_valid, bus.out_src, bus.out_imm} !==
                {~port_v[i], port_v[i], 1'b1, port_v[i], exp_v[i]}) begin
                tests_failed++;
                $display("FAIL ext%0d: got ack=%b%b valid=%b src=%b imm=%h want ack=%b%b valid=1 src=%b imm=%h",
                         i, bus.ack0, bus.ack1, bus.out_valid, bus.out_src, bus.out_imm,
                         ~port_v[i], port_v[i], port_v[i], exp_v[i]);
            end
            @(posedge clk); #1;
            bus.req0 = 1'b0; bus.req1 = 1'b0;
            @(negedge clk);
            tests_run++;
            if ({bus.out_valid, bus.ack0, bus.ack1} !== 3'b000) begin
                tests_failed++;
                $display("FAIL ext%0d_accept: got valid/ack=%b want 000", i, {bus.out_valid, bus.ack0, bus.ack1});
            end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [5:0] exp_ack0 = 6'b010001;
        logic [5:0] exp_ack1 = 6'b000100;
        logic [5:0] exp_src  = 6'b001100;
        apply_reset();
        bus.out_ready = 1'b1;
        drive_req(1'b0, 6'h01, 1'b1, 1'b0);
        drive_req(1'b1, 6'h02, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            tests_run++;
            if ({bus.ack0, bus.ack1} !== {exp_ack0[k], exp_ack1[k]}) begin
                tests_failed++;
                $display("FAIL rr_ack%0d: got %b%b want %b%b", k, bus.ack0, bus.ack1, exp_ack0[k], exp_ack1[k]);
            end
            if (exp_ack0[k] || exp_ack1[k]) begin
                tests_run++;
                if (bus.out_src !== exp_src[k]) begin
                    tests_failed++;
                    $display("FAIL rr_src%0d: got %b want %b", k, bus.out_src, exp_src[k]);
                end
            end
        end
        @(posedge clk); #1 idle_inputs();
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_in_valid();
        @(posedge clk); #1;
        drive_req(1'b0, 6'h3F, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstv_pre: got valid=%b want 1", bus.out_valid);
        end
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.ack0, bus.ack1, bus.out_valid, bus.out_src, bus.out_imm} !== 22'd0) begin
            tests_failed++;
            $display("FAIL rstv_async: got valid=%b imm=%h want 0 00000", bus.out_valid, bus.out_imm);
        end
        bus.req0 = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus.ack0, bus.out_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL rstv_post: got ack0/valid=%b want 00", {bus.ack0, bus.out_valid});
        end
    endtask

`ifdef IMM_PREFIX_EN
    task automatic test_prefix_merge();
        apply_reset();
        drive_req(1'b0, 6'h2A, 1'b0, 1'b1);
        drive_req(1'b1, 6'h07, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({bus.ack0, bus.ack1, bus.out_valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL pfx_first: got %b want 100", {bus.ack0, bus.ack1, bus.out_valid});
        end
        @(posedge clk); #1;
        drive_req(1'b0, 6'h15, 1'b0, 1'b0);
        @(negedge clk);
        tests_run++;
        if ({bus.ack0, bus.ack1, bus.out_valid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL pfx_gap: got %b want 000", {bus.ack0, bus.ack1, bus.out_valid});
        end
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({bus.ack0, bus.ack1, bus.out_valid, bus.out_src, bus.out_imm} !== {4'b1010, 18'h3FA95}) begin
            tests_failed++;
            $display("FAIL pfx_merge: got ack=%b%b valid=%b src=%b imm=%h want 1 0 1 0 3fa95",
                     bus.ack0, bus.ack1, bus.out_valid, bus.out_src, bus.out_imm);
        end
        @(posedge clk); #1 bus.req0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.ack1, bus.out_valid} !== 2'b01) begin
                tests_failed++;
                $display("FAIL pfx_wait%0d: got ack1/valid=%b want 01", i, {bus.ack1, bus.out_valid});
            end
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(posedge clk); #1 bus.out_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus.ack1, bus.out_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL pfx_accept: got ack1/valid=%b want 00", {bus.ack1, bus.out_valid});
        end
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({bus.ack1, bus.out_src, bus.out_imm} !== {2'b11, 18'h00007}) begin
            tests_failed++;
            $display("FAIL pfx_port1: got ack1=%b src=%b imm=%h want 1 1 00007", bus.ack1, bus.out_src, bus.out_imm);
        end
        @(posedge clk); #1 begin bus.req1 = 1'b0; bus.out_ready = 1'b1; end
        @(posedge clk); #1 bus.out_ready = 1'b0;
    endtask

    task automatic test_prefix_reset();
        apply_reset();
        bus.out_ready = 1'b1;
        drive_req(1'b0, 6'h3F, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({bus.ack0, bus.out_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL pfxr_lock: got ack0/valid=%b want 10", {bus.ack0, bus.out_valid});
        end
        @(posedge clk); #1 bus.req0 = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.ack0, bus.ack1, bus.out_valid, bus.out_src, bus.out_imm} !== 22'd0) begin
            tests_failed++;
            $display("FAIL pfxr_async: got valid=%b imm=%h want 0 00000", bus.out_valid, bus.out_imm);
        end
        @(posedge clk); #1 rst = 1'b0;
        drive_req(1'b0, 6'h15, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({bus.ack0, bus.out_valid, bus.out_imm} !== {2'b11, 18'h00015}) begin
            tests_failed++;
            $display("FAIL pfxr_fresh: got ack0=%b valid=%b imm=%h want 1 1 00015", bus.ack0, bus.out_valid, bus.out_imm);
        end
        @(posedge clk); #1 idle_inputs();
        @(posedge clk);
    endtask
`else
    task automatic test_pfx_ignored();
        apply_reset();
        drive_req(1'b0, 6'h3F, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({bus.ack0, bus.out_valid, bus.out_src, bus.out_imm} !== {3'b110, 18'h3FFFF}) begin
            tests_failed++;
            $display("FAIL nopfx_direct: got ack0=%b valid=%b src=%b imm=%h want 1 1 0 3ffff",
                     bus.ack0, bus.out_valid, bus.out_src, bus.out_imm);
        end
        @(posedge clk); #1 begin bus.req0 = 1'b0; bus.out_ready = 1'b1; end
        @(posedge clk); #1 bus.out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_hold_stable();
        test_extension();
        test_round_robin();
        test_reset_in_valid();
`ifdef IMM_PREFIX_EN
        test_prefix_merge();
        test_prefix_reset();
`else
        test_pfx_ignored();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
